// File: rtl/video_timing_pkg.sv
// video_timing_pkg
//   Shared raster timing constants for the sync generator and the
//   scandoubler top level.
//   - Default 15 kHz PAL-style timing, which matches the 48K raster.
//   - Timing sets for 48K, 128K and Pentagon, packed as video_timing_t.
//   - A half-open window test helper.
//   All window limits are 10 bits wide, so START+LEN up to 1023 does not
//   overflow.
package video_timing_pkg;

    localparam int unsigned DEF_H_TOTAL      = 448;
    localparam int unsigned DEF_V_TOTAL      = 312;
    localparam int unsigned DEF_HBLANK_START = 320;
    localparam int unsigned DEF_HBLANK_END   = 416;
    localparam int unsigned DEF_HSYNC_START  = 344;
    localparam int unsigned DEF_HSYNC_LEN    = 32;
    localparam int unsigned DEF_VBLANK_START = 248;
    localparam int unsigned DEF_VBLANK_END   = 256;
    localparam int unsigned DEF_VSYNC_START  = 248;
    localparam int unsigned DEF_VSYNC_LINES  = 4;

    typedef struct packed {
        logic [9:0] h_total;
        logic [9:0] v_total;
        logic [9:0] hblank_start;
        logic [9:0] hblank_end;
        logic [9:0] hsync_start;
        logic [9:0] hsync_len;
        logic [9:0] vblank_start;
        logic [9:0] vblank_end;
        logic [9:0] vsync_start;
        logic [9:0] vsync_lines;
    } video_timing_t;

    localparam video_timing_t TIMING_48K = '{
        h_total: 10'd448, v_total: 10'd312,
        hblank_start: 10'd320, hblank_end: 10'd416,
        hsync_start: 10'd344, hsync_len: 10'd32,
        vblank_start: 10'd248, vblank_end: 10'd256,
        vsync_start: 10'd248, vsync_lines: 10'd4
    };

    localparam video_timing_t TIMING_128K = '{
        h_total: 10'd456, v_total: 10'd311,
        hblank_start: 10'd320, hblank_end: 10'd424,
        hsync_start: 10'd344, hsync_len: 10'd32,
        vblank_start: 10'd248, vblank_end: 10'd256,
        vsync_start: 10'd248, vsync_lines: 10'd4
    };

    localparam video_timing_t TIMING_PENTAGON = '{
        h_total: 10'd448, v_total: 10'd320,
        hblank_start: 10'd320, hblank_end: 10'd416,
        hsync_start: 10'd328, hsync_len: 10'd32,
        vblank_start: 10'd240, vblank_end: 10'd256,
        vsync_start: 10'd240, vsync_lines: 10'd8
    };

    // Half-open window test: lo <= pos < hi.
    function automatic logic in_window(input logic [9:0] pos,
                                       input logic [9:0] lo,
                                       input logic [9:0] hi);
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage

// File: rtl/video_raster_counter.sv
// video_raster_counter
//   Horizontal and vertical raster counters with one-clk wrap pulses.
//   All state advances only when en_i is high. Both pulses are forced low
//   on any clk with en_i low, so each pulse lasts exactly one clk.
// Ports:
//   clk            system clock
//   rst            synchronous reset, active high
//   en_i           pixel clock enable
//   hc_o / vc_o    current horizontal / vertical count
//   line_start_o   high for one clk after the hc wrap
//   frame_start_o  high for one clk after the combined hc and vc wrap
module video_raster_counter
    import video_timing_pkg::*;
#(
    parameter int unsigned H_TOTAL = DEF_H_TOTAL,
    parameter int unsigned V_TOTAL = DEF_V_TOTAL
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    output logic [8:0] hc_o,
    output logic [8:0] vc_o,
    output logic       line_start_o,
    output logic       frame_start_o
);

    localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);

    logic [8:0] hc_q, hc_d;
    logic [8:0] vc_q, vc_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;

    always_comb begin
        hc_d          = hc_q;
        vc_d          = vc_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (en_i) begin
            if (hc_q == H_LAST) begin
                hc_d          = 9'd0;
                vc_d          = (vc_q == V_LAST) ? 9'd0 : vc_q + 9'd1;
                line_start_d  = 1'b1;
                frame_start_d = (vc_q == V_LAST);
            end else begin
                hc_d = hc_q + 9'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hc_q          <= 9'd0;
            vc_q          <= 9'd0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hc_o          = hc_q;
    assign vc_o          = vc_q;
    assign line_start_o  = line_start_q;
    assign frame_start_o = frame_start_q;

endmodule

// File: rtl/video_sync_gen.sv
// video_sync_gen
//   15 kHz PAL-style raster timing for the scandoubler.
//   - Raster counters, provided by video_raster_counter.
//   - Active-low hsync, vsync and composite sync.
//   - Blanking flag and blanked RGB.
//   Sync, blank and RGB are decoded from the counter values before the
//   increment and are registered on the same pixen tick. They therefore lag
//   hc/vc by one pixen tick.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   pixen                     pixel clock enable
//   ri/gi/bi                  3-bit pixel colour in, aligned with the current hc
//   hc/vc                     raster counters
//   ro/go/bo                  colour out, forced to 0 while blanked
//   hsync_n/vsync_n/csync_n   active-low syncs
//   blank                     high inside the blanking window
//   line_start/frame_start    one-clk wrap pulses
module video_sync_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_TOTAL      = DEF_H_TOTAL,
    parameter int unsigned V_TOTAL      = DEF_V_TOTAL,
    parameter int unsigned HBLANK_START = DEF_HBLANK_START,
    parameter int unsigned HBLANK_END   = DEF_HBLANK_END,
    parameter int unsigned HSYNC_START  = DEF_HSYNC_START,
    parameter int unsigned HSYNC_LEN    = DEF_HSYNC_LEN,
    parameter int unsigned VBLANK_START = DEF_VBLANK_START,
    parameter int unsigned VBLANK_END   = DEF_VBLANK_END,
    parameter int unsigned VSYNC_START  = DEF_VSYNC_START,
    parameter int unsigned VSYNC_LINES  = DEF_VSYNC_LINES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pixen,
    input  logic [2:0] ri,
    input  logic [2:0] gi,
    input  logic [2:0] bi,
    output logic [8:0] hc,
    output logic [8:0] vc,
    output logic [2:0] ro,
    output logic [2:0] go,
    output logic [2:0] bo,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       csync_n,
    output logic       blank,
    output logic       line_start,
    output logic       frame_start
);

    // Sync windows must not wrap around the end of a line or frame.
    if (HSYNC_START + HSYNC_LEN > H_TOTAL) begin : g_bad_hsync
        $error("video_sync_gen: HSYNC_START+HSYNC_LEN exceeds H_TOTAL");
    end
    if (VSYNC_START + VSYNC_LINES > V_TOTAL) begin : g_bad_vsync
        $error("video_sync_gen: VSYNC_START+VSYNC_LINES exceeds V_TOTAL");
    end
    if (H_TOTAL > 512 || V_TOTAL > 512) begin : g_bad_total
        $error("video_sync_gen: H_TOTAL and V_TOTAL must not exceed 512");
    end
    if (HSYNC_LEN < 1 || VSYNC_LINES < 1) begin : g_bad_len
        $error("video_sync_gen: sync lengths must be at least 1");
    end

    localparam logic [9:0] HS_LO = 10'(HSYNC_START);
    localparam logic [9:0] HS_HI = 10'(HSYNC_START + HSYNC_LEN);
    localparam logic [9:0] VS_LO = 10'(VSYNC_START);
    localparam logic [9:0] VS_HI = 10'(VSYNC_START + VSYNC_LINES);
    localparam logic [9:0] HB_LO = 10'(HBLANK_START);
    localparam logic [9:0] HB_HI = 10'(HBLANK_END);
    localparam logic [9:0] VB_LO = 10'(VBLANK_START);
    localparam logic [9:0] VB_HI = 10'(VBLANK_END);

    video_raster_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_counter (
        .clk           (clk),
        .rst           (rst),
        .en_i          (pixen),
        .hc_o          (hc),
        .vc_o          (vc),
        .line_start_o  (line_start),
        .frame_start_o (frame_start)
    );

    logic [9:0] hc_x, vc_x;
    logic       hs, vs, bl;

    logic       hsync_n_q, hsync_n_d;
    logic       vsync_n_q, vsync_n_d;
    logic       csync_n_q, csync_n_d;
    logic       blank_q, blank_d;
    logic [2:0] ro_q, ro_d;
    logic [2:0] go_q, go_d;
    logic [2:0] bo_q, bo_d;

    assign hc_x = {1'b0, hc};
    assign vc_x = {1'b0, vc};

    always_comb begin
        hs = in_window(hc_x, HS_LO, HS_HI);
        vs = in_window(vc_x, VS_LO, VS_HI);
        bl = in_window(hc_x, HB_LO, HB_HI) || in_window(vc_x, VB_LO, VB_HI);

        hsync_n_d = ~hs;
        vsync_n_d = ~vs;
        // During vsync lines the hsync pulse is inverted (serrated csync).
        csync_n_d = ~(hs ^ vs);
        blank_d   = bl;
        ro_d      = bl ? 3'd0 : ri;
        go_d      = bl ? 3'd0 : gi;
        bo_d      = bl ? 3'd0 : bi;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hsync_n_q <= 1'b1;
            vsync_n_q <= 1'b1;
            csync_n_q <= 1'b1;
            blank_q   <= 1'b1;
            ro_q      <= 3'd0;
            go_q      <= 3'd0;
            bo_q      <= 3'd0;
        end else if (pixen) begin
            hsync_n_q <= hsync_n_d;
            vsync_n_q <= vsync_n_d;
            csync_n_q <= csync_n_d;
            blank_q   <= blank_d;
            ro_q      <= ro_d;
            go_q      <= go_d;
            bo_q      <= bo_d;
        end
    end

    assign hsync_n = hsync_n_q;
    assign vsync_n = vsync_n_q;
    assign csync_n = csync_n_q;
    assign blank   = blank_q;
    assign ro      = ro_q;
    assign go      = go_q;
    assign bo      = bo_q;

endmodule
